// File: rtl/ldst_mem_responder_pkg.sv
// Shared constants, region type and address decoder for the load/store responder.
// Also imported by the bench scoreboard so both sides agree on region naming.
package ldst_mem_responder_pkg;

  localparam int          RAM_WORDS_DEF = 4096;
  localparam logic [15:0] LEDR_ADDR_DEF = 16'h2000;
  localparam logic [15:0] CNT_ADDR_DEF  = 16'h2002;
  localparam int          LEDR_W_DEF    = 10;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_LEDR = 2'd1,
    REG_CNT  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // RAM wins over the MMIO window so a large RAM_WORDS can shadow it safely.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int          ram_words,
                                            input logic [15:0] ledr_addr,
                                            input logic [15:0] cnt_addr);
    logic [31:0] ram_bytes;
    ram_bytes = 32'(2 * ram_words);
    if ({16'd0, addr} < ram_bytes)     return REG_RAM;
    if (addr[15:1] == ledr_addr[15:1]) return REG_LEDR;
    if (addr[15:1] == cnt_addr[15:1])  return REG_CNT;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/ldst_mem_responder_if.sv
// Load/store request/response bundle between the register-read stage and the data responder.
// The pipeline drives as master; the responder is the slave.
interface ldst_mem_responder_if;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] wrdata;
  logic [15:0] rddata;
  logic        rdvalid;

  modport master (output addr, rd, wr, wrdata, input rddata, rdvalid);
  modport slave  (input addr, rd, wr, wrdata, output rddata, rdvalid);
endinterface

// File: rtl/ldst_mem_responder_mmio.sv
// LED register and free-running cycle counter with registered read data.
// Counter loads on write, otherwise increments every cycle; reads sample pre-increment value.
module ldst_mmio_regs #(
  parameter int LEDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ledr_we,
  input  logic              cnt_we,
  input  logic [15:0]       wrdata,
  input  logic              ledr_re,
  input  logic              cnt_re,
  output logic [LEDR_W-1:0] ledr,
  output logic [15:0]       cnt,
  output logic [15:0]       rddata
);

  logic [LEDR_W-1:0] ledr_q;
  logic [15:0]       cnt_q;
  logic [15:0]       rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledr_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      if (ledr_we) ledr_q <= wrdata[LEDR_W-1:0];
      cnt_q <= cnt_we ? wrdata : cnt_q + 16'd1;
      // rd_q only moves on an MMIO load so the top-level output can hold across idles.
      if (ledr_re)     rd_q <= 16'(ledr_q);
      else if (cnt_re) rd_q <= cnt_q;
    end
  end

  assign ledr   = ledr_q;
  assign cnt    = cnt_q;
  assign rddata = rd_q;

endmodule

// File: rtl/ldst_mem_responder.sv
// Data-side load/store responder: word RAM plus LED/counter MMIO, one-cycle load latency.
// Never stalls; protocol and unmapped-access errors latch into a sticky flag.
module ldst_mem_responder
  import ldst_mem_responder_pkg::*;
#(
  parameter int          RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [15:0] LEDR_ADDR = LEDR_ADDR_DEF,
  parameter logic [15:0] CNT_ADDR  = CNT_ADDR_DEF,
  parameter int          LEDR_W    = LEDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ldst_mem_responder_if.slave bus,
  output logic [LEDR_W-1:0] ledr,
  output logic [15:0]       cnt,
  output logic              err
);

  localparam int AW = $clog2(RAM_WORDS);

  region_e        region;
  logic           do_rd;
  logic           do_wr;
  logic [AW-1:0]  widx;
  logic [15:0]    ram [RAM_WORDS];
  logic [15:0]    ram_q;
  region_e        rd_sel;
  logic           rdvalid_q;
  logic           err_q;
  logic [15:0]    mmio_rd;
  logic [15:0]    rddata_mux;

  assign region = decode_region(bus.addr, RAM_WORDS, LEDR_ADDR, CNT_ADDR);
  assign do_wr  = bus.wr;
  // A simultaneous rd+wr keeps the store and drops the load.
  assign do_rd  = bus.rd & ~bus.wr;
  assign widx   = bus.addr[AW:1];

  always_ff @(posedge clk) begin
    if (do_wr && region == REG_RAM) ram[widx] <= bus.wrdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_q     <= '0;
      rd_sel    <= REG_NONE;
      rdvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rdvalid_q <= do_rd;
      if (do_rd) begin
        rd_sel <= region;
        if (region == REG_RAM) ram_q <= ram[widx];
      end
      if ((bus.rd && bus.wr) || ((bus.rd || bus.wr) && region == REG_NONE))
        err_q <= 1'b1;
    end
  end

  ldst_mmio_regs #(.LEDR_W(LEDR_W)) u_mmio (
    .clk     (clk),
    .reset   (reset),
    .ledr_we (do_wr && region == REG_LEDR),
    .cnt_we  (do_wr && region == REG_CNT),
    .wrdata  (bus.wrdata),
    .ledr_re (do_rd && region == REG_LEDR),
    .cnt_re  (do_rd && region == REG_CNT),
    .ledr    (ledr),
    .cnt     (cnt),
    .rddata  (mmio_rd)
  );

  // Every mux source and the select are registers that only move on loads, so data holds on idle.
  always_comb begin
    rddata_mux = '0;
    case (rd_sel)
      REG_RAM:          rddata_mux = ram_q;
      REG_LEDR, REG_CNT: rddata_mux = mmio_rd;
      default:          rddata_mux = '0;
    endcase
  end

  assign bus.rddata  = rddata_mux;
  assign bus.rdvalid = rdvalid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Bench for ldst_mem_responder: directed table, corner-case sequences and a random
// run checked against a memory-map scoreboard.
module tb_ldst_mem_responder;
  import ldst_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  ledr;
  logic [15:0] cnt;
  logic        err;

  ldst_mem_responder_if bus();

  ldst_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ledr  (ledr),
    .cnt   (cnt),
    .err   (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard state: the architectural memory map as the pipeline sees it.
  logic [15:0] m_mem [4096];
  bit          m_known [4096];
  logic [9:0]  m_ledr;
  logic [15:0] m_cnt;
  bit          m_err;
  bit          m_vld;
  logic [15:0] m_dat;
  bit          m_dat_known;

  typedef struct packed {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    bit          chk_dat;
    bit          exp_vld;
    logic [15:0] exp_dat;
    bit          chk_cnt;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic region_e model_region(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai < 2 * 4096)        return REG_RAM;
    if (a[15:1] == 15'h1000)  return REG_LEDR;
    if (a[15:1] == 15'h1001)  return REG_CNT;
    return REG_NONE;
  endfunction

  task automatic model_clear();
    m_ledr = '0; m_cnt = '0; m_err = 0; m_vld = 0; m_dat = '0; m_dat_known = 1;
  endtask

  task automatic model_edge(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    region_e r;
    logic [15:0] cnt_next;
    r = model_region(a);
    cnt_next = m_cnt + 16'd1;
    m_vld = 0;
    if (rd && wr) m_err = 1;
    if (wr) begin
      case (r)
        REG_RAM:  begin m_mem[a[12:1]] = wd; m_known[a[12:1]] = 1; end
        REG_LEDR: m_ledr = wd[9:0];
        REG_CNT:  cnt_next = wd;
        default:  m_err = 1;
      endcase
    end else if (rd) begin
      m_vld = 1;
      m_dat_known = 1;
      case (r)
        REG_RAM:  begin m_dat = m_mem[a[12:1]]; m_dat_known = m_known[a[12:1]]; end
        REG_LEDR: m_dat = {6'd0, m_ledr};
        REG_CNT:  m_dat = m_cnt;
        default:  begin m_dat = 16'h0000; m_err = 1; end
      endcase
    end
    m_cnt = cnt_next;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".rdvalid"}, {15'd0, bus.rdvalid}, {15'd0, m_vld});
    if (m_dat_known) chk({tag, ".rddata"}, bus.rddata, m_dat);
    chk({tag, ".ledr"}, {6'd0, ledr}, {6'd0, m_ledr});
    chk({tag, ".cnt"}, cnt, m_cnt);
    chk({tag, ".err"}, {15'd0, err}, {15'd0, m_err});
  endtask

  // One clock: drive at edge+1, update model for the coming edge, sample at next edge+1.
  task automatic apply(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       input string tag);
    bus.rd = rd; bus.wr = wr; bus.addr = a; bus.wrdata = wd;
    model_edge(rd, wr, a, wd);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_clear();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst.rddata", bus.rddata, 16'h0000);
      chk("rst.rdvalid", {15'd0, bus.rdvalid}, 16'h0000);
      chk("rst.ledr", {6'd0, ledr}, 16'h0000);
      chk("rst.cnt", cnt, 16'h0000);
      chk("rst.err", {15'd0, err}, 16'h0000);
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wrdata = '0;
    for (int k = 0; k < 4096; k++) begin m_mem[k] = '0; m_known[k] = 0; end
    model_clear();

    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 16'h0100, 16'h5678, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h5678, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, 16'h2000, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 1'b1, 16'h03FF, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 16'h2002, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 16'h2002, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0001};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};

    // Power-on reset.
    do_reset(3);

    // Reset dropped on top of an in-flight load.
    apply(1'b0, 1'b1, 16'h0040, 16'h7777, "pre");
    apply(1'b1, 1'b0, 16'h0040, 16'h0000, "inflight");
    chk("inflight.vld", {15'd0, bus.rdvalid}, 16'h0001);
    do_reset(3);
    apply(1'b0, 1'b0, 16'h0000, 16'h0000, "post_rst");
    chk("post_rst.no_vld", {15'd0, bus.rdvalid}, 16'h0000);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.vld", i), {15'd0, bus.rdvalid}, {15'd0, tbl[i].exp_vld});
      if (tbl[i].chk_dat) chk($sformatf("tbl%0d.dat", i), bus.rddata, tbl[i].exp_dat);
      if (tbl[i].chk_cnt) chk($sformatf("tbl%0d.cnt", i), cnt, tbl[i].exp_cnt);
      if (i == 6) chk("tbl6.ledr", {6'd0, ledr}, 16'h03FF);
    end

    // Fill then back-to-back loads at full rate.
    for (int i = 0; i < 8; i++)
      apply(1'b0, 1'b1, 16'(2 * i), 16'h1000 + 16'(i), "fill");
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 16'(2 * i), 16'h0000, "b2b");
      chk($sformatf("b2b%0d.vld", i), {15'd0, bus.rdvalid}, 16'h0001);
      chk($sformatf("b2b%0d.dat", i), bus.rddata, 16'h1000 + 16'(i));
    end

    // Unmapped load.
    apply(1'b1, 1'b0, 16'h3000, 16'h0000, "unmapped");
    chk("unmapped.dat", bus.rddata, 16'h0000);
    chk("unmapped.vld", {15'd0, bus.rdvalid}, 16'h0001);
    chk("unmapped.err", {15'd0, err}, 16'h0001);

    // rd and wr together: store wins, no load, error latched.
    do_reset(1);
    apply(1'b1, 1'b1, 16'h0020, 16'hAAAA, "rdwr");
    chk("rdwr.vld", {15'd0, bus.rdvalid}, 16'h0000);
    chk("rdwr.err", {15'd0, err}, 16'h0001);
    apply(1'b0, 1'b0, 16'h0000, 16'h0000, "rdwr_idle");
    apply(1'b1, 1'b0, 16'h0020, 16'h0000, "rdwr_ld");
    chk("rdwr_ld.dat", bus.rddata, 16'hAAAA);

    // Random traffic against the scoreboard.
    do_reset(1);
    for (int i = 0; i < 64; i++)
      apply(1'b0, 1'b1, 16'(2 * i), 16'($urandom), "pre_fill");
    apply(1'b0, 1'b1, 16'h1FFE, 16'($urandom), "pre_fill_top");
    for (int i = 0; i < 800; i++) begin
      int sel, op;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 7);
      case (sel)
        6:       a = 16'h1FFE | 16'($urandom_range(0, 1));
        7:       a = 16'h2000 | 16'($urandom_range(0, 1));
        8:       a = 16'h2002 | 16'($urandom_range(0, 1));
        9:       a = ($urandom_range(0, 1) == 1) ? 16'h3000 : 16'h2004 + 16'($urandom_range(0, 8000));
        default: a = 16'($urandom_range(0, 16'h7F));
      endcase
      if (i % 200 == 199) do_reset($urandom_range(1, 3));
      apply(op < 3 || op == 5, op == 3 || op == 4 || op == 5, a, 16'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
